// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the binary-to-BCD converter and the 7-segment display driver.
// Combinational-only content; no latency or backpressure of its own.
package bcd_disp_pkg;

  localparam int NUM_W      = 14;
  localparam int DIGITS     = 4;
  localparam int BCD_W      = 4;
  localparam int SCR_DIGITS = DIGITS + 1;
  localparam int CNT_W      = 4;
  localparam logic [NUM_W-1:0] MAX_VAL = 14'd9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } b2b_state_e;

  // Elaboration-time helper: packed BCD digits of a constant, least significant digit in the LSBs.
  function automatic logic [DIGITS*BCD_W-1:0] to_bcd(input int unsigned v);
    logic [DIGITS*BCD_W-1:0] r;
    int unsigned rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  localparam logic [DIGITS*BCD_W-1:0] SAT_BCD = to_bcd(int'(MAX_VAL));

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Purely combinational, zero latency, no backpressure.
module bcd_add3_digit
  import bcd_disp_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_W'(5)) begin
      d_o = d_i + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_4dig.sv
// 14-bit binary to 4-digit BCD, one bit per clock; digits valid 15 cycles after start is accepted.
// start is sampled only when idle and never queued; build with BIN2BCD_SAT_EN to clamp overflow to 9999.
module bin_to_bcd_4dig
  import bcd_disp_pkg::*;
(
  input  logic             m_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [NUM_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [BCD_W-1:0] bcd0,
  output logic [BCD_W-1:0] bcd1,
  output logic [BCD_W-1:0] bcd2,
  output logic [BCD_W-1:0] bcd3
);

  localparam int SCR_W = SCR_DIGITS * BCD_W;
  localparam int DIG_W = DIGITS * BCD_W;

  b2b_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NUM_W-1:0] shreg_q;
  logic [SCR_W-1:0] scr_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;
  logic [DIG_W-1:0] dig_q;

  logic [SCR_W-1:0]       scr_adj;
  logic [SCR_W+NUM_W-1:0] shift_cat;
  logic                   ovf_d;
  logic [DIG_W-1:0]       dig_d;

  for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .d_i (scr_q[g*BCD_W +: BCD_W]),
      .d_o (scr_adj[g*BCD_W +: BCD_W])
    );
  end

  // The MSB shifted out is always zero: five digits hold every 14-bit value.
  assign shift_cat = {scr_adj, shreg_q} << 1;

  always_comb begin
    ovf_d = (scr_q[SCR_W-1:DIG_W] != '0) || (scr_q[DIG_W-1:0] > SAT_BCD);
    dig_d = scr_q[DIG_W-1:0];
`ifdef BIN2BCD_SAT_EN
    if (ovf_d) begin
      dig_d = SAT_BCD;
    end
`endif
  end

  always_ff @(posedge m_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      scr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q <= bin_in;
            scr_q   <= '0;
            cnt_q   <= CNT_W'(NUM_W - 1);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q   <= shift_cat[SCR_W+NUM_W-1:NUM_W];
          shreg_q <= shift_cat[NUM_W-1:0];
          if (cnt_q == '0) begin
            state_q <= FINISH;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FINISH: begin
          dig_q   <= dig_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd0 = dig_q[0*BCD_W +: BCD_W];
  assign bcd1 = dig_q[1*BCD_W +: BCD_W];
  assign bcd2 = dig_q[2*BCD_W +: BCD_W];
  assign bcd3 = dig_q[3*BCD_W +: BCD_W];

endmodule

// File: tb/tb_bin_to_bcd_4dig.sv
// Directed bench for bin_to_bcd_4dig; expected digits come from a decimal reference model via a queue.
module tb_bin_to_bcd_4dig;

  logic        m_clk   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [13:0] bin_in  = '0;
  logic        busy, done, ovf;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3;

  bin_to_bcd_4dig dut (
    .m_clk   (m_clk),
    .reset_n (reset_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd0    (bcd0),
    .bcd1    (bcd1),
    .bcd2    (bcd2),
    .bcd3    (bcd3)
  );

  initial forever #5 m_clk = ~m_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [15:0] dig;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input int v);
    exp_t e;
    int   m;
    e.ovf = (v > 9999);
    m     = v % 10000;
`ifdef BIN2BCD_SAT_EN
    if (e.ovf) m = 9999;
`endif
    e.dig = {4'(m / 1000), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    chk({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_digits"}, {bcd3, bcd2, bcd1, bcd0}, e.dig);
      chk({tag, "_ovf"}, ovf, e.ovf);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_digits"}, {bcd3, bcd2, bcd1, bcd0}, 0);
  endtask

  // Single conversion: latency, busy width, result, one-cycle done.
  task automatic run_conv(input logic [13:0] v, input string tag);
    int n;
    int bc;
    bin_in = v;
    start  = 1'b1;
    exp_q.push_back(model(int'(v)));
    @(negedge m_clk);
    start = 1'b0;
    bc = busy ? 1 : 0;
    n  = 0;
    while (!done && n < 40) begin
      @(negedge m_clk);
      n++;
      if (busy) bc++;
    end
    chk({tag, "_latency"}, n, 15);
    chk({tag, "_busy_cycles"}, bc, 15);
    if (done) check_result(tag);
    @(negedge m_clk);
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int n;
    int cnt;

    repeat (3) @(negedge m_clk);
    check_idle_zero("reset");
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge m_clk);
      if (busy || done) cnt++;
    end
    chk("idle_no_busy", cnt, 0);
    check_idle_zero("idle_after_release");

    run_conv(14'd1234, "c1234");

    // Start held high across two conversions: second accepted while done is high.
    bin_in = 14'd0;
    start  = 1'b1;
    exp_q.push_back(model(0));
    @(negedge m_clk);
    bin_in = 14'd9999;
    n = 0;
    while (!done && n < 40) begin
      @(negedge m_clk);
      n++;
    end
    chk("b2b0_latency", n, 15);
    if (done) check_result("b2b0");
    exp_q.push_back(model(9999));
    @(negedge m_clk);
    start = 1'b0;
    chk("b2b_second_accepted", busy, 1);
    n = 1;
    while (!done && n < 40) begin
      @(negedge m_clk);
      n++;
    end
    chk("b2b_done_spacing", n, 16);
    if (done) check_result("b2b9999");

    run_conv(14'd12000, "c12000");
    run_conv(14'd16383, "c16383");
    run_conv(14'd10000, "c10000");

    // start and bin_in changes during a conversion must be ignored.
    bin_in = 14'd55;
    start  = 1'b1;
    exp_q.push_back(model(55));
    @(negedge m_clk);
    start = 1'b0;
    repeat (4) @(negedge m_clk);
    bin_in = 14'd77;
    start  = 1'b1;
    @(negedge m_clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        cnt++;
        check_result("ignored_start");
      end
      @(negedge m_clk);
    end
    chk("ignored_start_done_count", cnt, 1);

    // Reset mid-conversion aborts with no result and no done.
    run_conv(14'd1234, "pre_abort");
    bin_in = 14'd4321;
    start  = 1'b1;
    @(negedge m_clk);
    start = 1'b0;
    repeat (7) @(negedge m_clk);
    reset_n = 1'b0;
    #1;
    check_idle_zero("abort");
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge m_clk);
      if (done || busy) cnt++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge m_clk);
      if (done || busy) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_digits_held", {bcd3, bcd2, bcd1, bcd0}, 0);
    run_conv(14'd8765, "post_abort");
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_4dig.md
# bin_to_bcd_4dig

Sequential binary-to-BCD converter that feeds the four-digit multiplexed seven-segment display driver. It takes a 14-bit binary count from the upstream counter or measurement logic. It produces four registered BCD digits, units through thousands, using iterative shift-add-3 (double dabble), one bit per clock. A start/busy/done handshake lets the producer launch a conversion and know when the digits are valid. The display stage reads the digit registers directly.

## Interface
- NUM_W, 14: binary input width; fixed to cover 0..16383.
- DIGITS, 4: number of BCD output digits.
- m_clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  14  binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when the digit outputs have just updated.
- ovf  output  1  registered; set when the captured bin_in > 9999.
- bcd0, bcd1, bcd2, bcd3  output  4 each  units, tens, hundreds, thousands digits.

## Operation
- FSM states: IDLE, SHIFT, FINISH.
- IDLE, start=1:
  - capture bin_in into a 14-bit shift register.
  - clear the 20-bit internal BCD scratch (5 digits) and set bit counter = 13.
  - busy<=1; go to SHIFT.
- IDLE, start=0: hold all state.
- SHIFT, each cycle:
  - every scratch digit >= 5 gets +3, combinationally.
  - then {scratch, shreg} shifts left by 1.
  - when counter = 0, go to FINISH; otherwise decrement the counter.
- FINISH:
  - load bcd0..bcd3 from scratch digits 0..3.
  - ovf <= (scratch digit 4 != 0) or (digits 3..0 > 9999).
  - done<=1 for this edge only; busy<=0; go to IDLE.
- start while busy is ignored. It is not queued.
- bin_in changes after capture have no effect.
- Digit outputs and ovf hold their last result until the next FINISH.
- Internal scratch is 5 digits, so every 14-bit value converts exactly. Out-of-range handling is governed by the Configuration macro.

## Timing
- Reset values: busy=0, done=0, ovf=0, bcd0..bcd3=0, state=IDLE, counter=0. The display shows 0000 out of reset.
- Start accepted at edge E0 → busy=1 after E0.
- SHIFT occupies edges E1..E14, one per input bit.
- FINISH is entered after E14. At E15, digits and ovf update, done=1 for one cycle, and busy=0.
- Latency is 15 cycles from the accepting edge to valid digits. done is high in the cycle after E15.
- Back-to-back operation: start may be reasserted in the cycle done is high (state is IDLE). It is then accepted at E16, giving a throughput of one conversion per 16 cycles.
- reset_n low at any point aborts immediately to the reset values. There is no partial result and no done pulse.

## Configuration
- Macro: BIN2BCD_SAT_EN.
- Defined: when ovf is set, bcd3..bcd0 are forced to 9,9,9,9 (display saturates at 9999).
- Undefined: the digits show value mod 10000 (scratch digit 4 is discarded); ovf is still reported.

## Structure
- Shared package `bcd_disp_pkg`:
  - constants NUM_W=14, DIGITS=4, BCD_W=4, MAX_VAL=14'd9999.
  - FSM state typedef (IDLE/SHIFT/FINISH, 2-bit encoding).
  - reused by the display driver for digit width.
- One natural sub-module, `bcd_add3_digit`: 4-bit combinational correction (d>=5 ? d+3 : d). It is instantiated 5 times in the scratch path.
- The top holds the FSM, counter, shift registers and output registers.

## Test plan
- Reset release, no start → all outputs 0; busy never rises.
- bin_in=1234, start for 1 cycle → busy for 15 cycles; done pulse; bcd3..0 = 1,2,3,4; ovf=0.
- bin_in=0, then bin_in=9999 back-to-back (start held) → 0,0,0,0, then 9,9,9,9 on successive done pulses 16 cycles apart; ovf=0 both times.
- bin_in=12000 → ovf=1; digits 9,9,9,9 with BIN2BCD_SAT_EN, otherwise 2,0,0,0. Repeat with 16383 → 9999 or 6383 respectively.
- start=1 with bin_in=55 accepted; at cycle 5 change bin_in=77 and pulse start → result 0,0,5,5; exactly one done pulse.
- Convert 1234, then start 4321 and assert reset_n low at cycle 8 → all outputs 0 immediately, no done pulse; a fresh conversion after release is correct.
